// File: rtl/microarchtrace_pkg.sv
// Shared types, record layout and record packing helpers for the per-stage PC trace packer.
// Records are 40 bits wide: 32-bit payload (timestamp or PC) plus 8 bits of kind/metadata.
package microarchtrace_pkg;

  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_DROP_W = 6;
  localparam int STAGE_ID_W   = 3;
  localparam int REC_W        = TRACE_PC_W + 8;

  // Bit 39 of every record distinguishes a cycle header from a slot event.
  localparam logic REC_KIND_HEADER = 1'b0;
  localparam logic REC_KIND_EVENT  = 1'b1;

  typedef enum logic [STAGE_ID_W-1:0] {
    STG_WB     = 3'd0,
    STG_COMMIT = 3'd1,
    STG_EX1    = 3'd2,
    STG_EX2    = 3'd3,
    STG_EX3    = 3'd4,
    STG_DEC    = 3'd5,
    STG_ALN    = 3'd6
  } stage_id_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_EVENTS = 2'd2
  } state_e;

  function automatic logic [REC_W-1:0] pack_header(
    input logic                    ovf,
    input logic [TRACE_DROP_W-1:0] drop_cnt,
    input logic [TRACE_PC_W-1:0]   ts
  );
    return {REC_KIND_HEADER, ovf, drop_cnt, ts};
  endfunction

  function automatic logic [REC_W-1:0] pack_event(
    input logic [STAGE_ID_W-1:0] stage_id,
    input logic                  slot,
    input logic [TRACE_PC_W-1:0] pc
  );
    return {REC_KIND_EVENT, stage_id, slot, 3'b000, pc};
  endfunction

endpackage

// File: rtl/microarchtrace_prio_pick.sv
// Find-first-set on a request vector: lowest set bit wins.
// Returns its index, a one-hot copy of it, and whether any bit is set.
module microarchtrace_prio_pick #(
  parameter  int W     = 14,
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic [W-1:0]     onehot,
  output logic             any
);

  // Scan downwards so the last hit written is the lowest set bit.
  always_comb begin
    idx    = '0;
    onehot = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/microarchtrace_stream_packer.sv
// Serialises per-cycle stage PC events into a header + event record stream over valid/ready.
// Optional per-stage filtering is enabled by defining MICROARCHTRACE_STAGE_MASK_EN.
module microarchtrace_stream_packer
  import microarchtrace_pkg::*;
#(
  parameter int NUM_STAGES = 7,
  parameter int PC_W       = TRACE_PC_W,
  parameter int TS_W       = TRACE_PC_W,
  parameter int DROP_W     = TRACE_DROP_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*NUM_STAGES-1:0]      ev_valid,
  input  logic [2*NUM_STAGES*PC_W-1:0] ev_pc,
`ifdef MICROARCHTRACE_STAGE_MASK_EN
  input  logic [NUM_STAGES-1:0]        stage_mask,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W+7:0]              out_data,
  output logic                         busy
);

  // Handshake: a record transfers on a rising clk edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_valid and out_data hold stable.

  localparam int NEV   = 2 * NUM_STAGES;
  localparam int IDX_W = (NEV > 1) ? $clog2(NEV) : 1;

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] HEADER = ST_HEADER;
  localparam logic [1:0] EVENTS = ST_EVENTS;

  logic [1:0]             state_q;
  logic [TS_W-1:0]        ts_q;
  logic                   ovf_q;
  logic [DROP_W-1:0]      drop_q;

  // Snapshot of the captured cycle.
  logic [NEV-1:0]         mask_q;
  logic [NEV*PC_W-1:0]    pc_q;
  logic [TS_W-1:0]        snap_ts_q;
  logic                   snap_ovf_q;
  logic [DROP_W-1:0]      snap_drop_q;

  logic [NEV-1:0]         ev_eff;
  logic                   ev_any;
  logic [IDX_W-1:0]       pick_idx;
  logic [NEV-1:0]         pick_onehot;
  logic                   pick_any;
  logic [NEV-1:0]         mask_rest;
  logic                   last_hs;
  logic                   capture;
  logic                   drop;

`ifdef MICROARCHTRACE_STAGE_MASK_EN
  // A masked-off stage looks exactly like an idle stage to everything downstream.
  always_comb begin
    ev_eff = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      ev_eff[2*s +: 2] = ev_valid[2*s +: 2] & {2{stage_mask[s]}};
    end
  end
`else
  assign ev_eff = ev_valid;
`endif

  assign ev_any = |ev_eff;

  microarchtrace_prio_pick #(
    .W (NEV)
  ) u_pick (
    .req    (mask_q),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  assign mask_rest = mask_q & ~pick_onehot;

  // The final event handshake frees the snapshot in time to capture this cycle.
  assign last_hs = (state_q == EVENTS) && out_ready && pick_any && (mask_rest == '0);
  assign capture = ev_any && ((state_q == IDLE) || last_hs);
  assign drop    = ev_any && !capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ts_q        <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
      mask_q      <= '0;
      pc_q        <= '0;
      snap_ts_q   <= '0;
      snap_ovf_q  <= 1'b0;
      snap_drop_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (capture) begin
        state_q     <= HEADER;
        mask_q      <= ev_eff;
        pc_q        <= ev_pc;
        snap_ts_q   <= ts_q;
        snap_ovf_q  <= ovf_q;
        snap_drop_q <= drop_q;
        ovf_q       <= 1'b0;
        drop_q      <= '0;
      end else begin
        if (drop) begin
          ovf_q <= 1'b1;
          if (drop_q != {DROP_W{1'b1}}) begin
            drop_q <= drop_q + 1'b1;
          end
        end
        case (state_q)
          HEADER: begin
            if (out_ready) begin
              state_q <= EVENTS;
            end
          end
          EVENTS: begin
            if (out_ready) begin
              mask_q <= mask_rest;
              if (mask_rest == '0) begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);

  // Event stage id is the pair index; slot is the low bit of the flat index.
  always_comb begin
    out_data = '0;
    case (state_q)
      HEADER:  out_data = pack_header(snap_ovf_q, snap_drop_q, snap_ts_q);
      EVENTS:  out_data = pack_event(STAGE_ID_W'(pick_idx >> 1), pick_idx[0],
                                     pc_q[pick_idx*PC_W +: PC_W]);
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_microarchtrace_stream_packer.sv
// Directed scoreboard bench for microarchtrace_stream_packer.
// Build with MICROARCHTRACE_STAGE_MASK_EN defined to also exercise stage filtering.
module tb_microarchtrace_stream_packer;

  localparam int NS   = 7;
  localparam int NEV  = 2 * NS;
  localparam int PCW  = 32;
  localparam int RECW = PCW + 8;

  logic                clk;
  logic                rst;
  logic [NEV-1:0]      ev_valid;
  logic [NEV*PCW-1:0]  ev_pc;
`ifdef MICROARCHTRACE_STAGE_MASK_EN
  logic [NS-1:0]       stage_mask;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [RECW-1:0]     out_data;
  logic                busy;

  logic [RECW-1:0]     exp_q[$];
  int                  n_cmp;
  int                  n_err;
  logic [31:0]         tb_ts;
  logic                hold_v;
  logic [RECW-1:0]     hold_d;

  microarchtrace_stream_packer #(
    .NUM_STAGES (NS),
    .PC_W       (PCW),
    .TS_W       (PCW),
    .DROP_W     (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_pc      (ev_pc),
`ifdef MICROARCHTRACE_STAGE_MASK_EN
    .stage_mask (stage_mask),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // Clock / reset-aware reference timestamp
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed=running required=finished");
    $fatal(1);
  end

  // Record layout helpers
  function automatic logic [RECW-1:0] hdr(input logic ovf, input logic [5:0] drop, input logic [31:0] ts);
    return {1'b0, ovf, drop, ts};
  endfunction

  function automatic logic [RECW-1:0] evr(input int idx, input logic [31:0] pc);
    logic [2:0] sid;
    logic       slot;
    sid  = 3'(idx / 2);
    slot = (idx % 2) == 1;
    return {1'b1, sid, slot, 3'b000, pc};
  endfunction

  function automatic logic [31:0] pc_of(input int idx);
    return 32'h1000 + 32'(4 * idx);
  endfunction

  task automatic check(input string tag, input logic [RECW-1:0] obs, input logic [RECW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input int idx, input logic [31:0] pc);
    ev_pc[idx*PCW +: PCW] = pc;
  endtask

  // Drive a capture of `mask` (PCs from pc_of) and queue the records it must produce.
  task automatic drive_capture(input logic [NEV-1:0] mask, input logic ovf, input logic [5:0] drop);
    ev_valid = mask;
    for (int i = 0; i < NEV; i++) set_pc(i, pc_of(i));
    exp_q.push_back(hdr(ovf, drop, tb_ts));
    for (int i = 0; i < NEV; i++) begin
      if (mask[i]) exp_q.push_back(evr(i, pc_of(i)));
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, {38'd0, busy, 1'b0}, '0);
    check({tag, "_pending"}, RECW'(exp_q.size()), '0);
  endtask

  // Scoreboard monitor: pops on every handshake, checks hold-stability during stalls.
  always @(negedge clk) begin
    logic [RECW-1:0] exp_rec;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid_hold", {39'd0, out_valid}, 40'd1);
        check("stall_data_hold", out_data, hold_d);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", out_data, 40'hx);
        end else begin
          exp_rec = exp_q.pop_front();
          check("record", out_data, exp_rec);
        end
      end
      hold_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
      hold_d = out_data;
    end
  end

  // Directed stimulus
  initial begin
    int  busy_cnt;
    int  k;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    n_cmp     = 0;
    n_err     = 0;
    hold_v    = 1'b0;
    hold_d    = '0;
    rst       = 1'b1;
    ev_valid  = '0;
    ev_pc     = '0;
    out_ready = 1'b0;
`ifdef MICROARCHTRACE_STAGE_MASK_EN
    stage_mask = '1;
`endif
    tick();
    tick();
    check("reset_out_valid", {39'd0, out_valid}, '0);
    check("reset_out_data", out_data, '0);
    check("reset_busy", {39'd0, busy}, '0);
    rst = 1'b0;

    // Single commit s0 event captured at ts 5.
    repeat (5) tick();
    out_ready = 1'b1;
    ev_valid  = 14'b00_0000_0000_0100;
    set_pc(2, 32'h8000_0010);
    exp_q.push_back(40'h00_0000_0005);
    exp_q.push_back(40'h90_8000_0010);
    tick();
    ev_valid = '0;
    check("t1_header", out_data, 40'h00_0000_0005);
    tick();
    check("t1_event", out_data, 40'h90_8000_0010);
    tick();
    check("t1_idle", {39'd0, out_valid}, '0);
    wait_idle("t1", 5);

    // All 14 slots, consumer always ready.
    drive_capture('1, 1'b0, 6'd0);
    tick();
    ev_valid = '0;
    busy_cnt = 0;
    repeat (20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
    check("t2_busy_cycles", RECW'(busy_cnt), 40'd15);
    wait_idle("t2", 5);

    // All 14 slots, ready toggling 1,0,0,1.
    drive_capture('1, 1'b0, 6'd0);
    tick();
    ev_valid = '0;
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      out_ready = pat[k % 4];
      tick();
      k++;
    end
    out_ready = 1'b1;
    wait_idle("t3", 5);

    // Two drops, then a back-to-back capture on the last handshake.
    drive_capture(14'b00_0000_0000_0011, 1'b0, 6'd0);
    tick();
    ev_valid = 14'b00_0000_0001_0000;
    tick();
    tick();
    drive_capture(14'b00_0000_0001_0000, 1'b1, 6'd2);
    tick();
    ev_valid = '0;
    check("t4_b2b_header", out_data, hdr(1'b1, 6'd2, tb_ts - 1));
    wait_idle("t4a", 10);
    drive_capture(14'b10_0000_0000_0000, 1'b0, 6'd0);
    tick();
    ev_valid = '0;
    wait_idle("t4b", 10);

    // 70 drops during a held stall saturate drop_cnt.
    out_ready = 1'b0;
    drive_capture(14'b00_0000_0000_0001, 1'b0, 6'd0);
    tick();
    ev_valid = 14'b00_0000_0000_0001;
    repeat (70) tick();
    ev_valid  = '0;
    out_ready = 1'b1;
    wait_idle("t5a", 10);
    drive_capture(14'b00_0000_0000_0001, 1'b1, 6'd63);
    tick();
    ev_valid = '0;
    check("t5_sat_header", out_data[39:32], 8'h7F);
    wait_idle("t5b", 10);

    // Reset asserted mid-EVENTS with drops pending.
    drive_capture('1, 1'b0, 6'd0);
    tick();
    ev_valid = 14'b00_0000_0000_0001;
    tick();
    ev_valid = '0;
    tick();
    check("t6_pre_reset_valid", {39'd0, out_valid}, 40'd1);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("t6_async_valid", {39'd0, out_valid}, '0);
    check("t6_async_data", out_data, '0);
    check("t6_async_busy", {39'd0, busy}, '0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    ev_valid = 14'b10_0000_0000_0000;
    set_pc(13, 32'hDEAD_BEEC);
    exp_q.push_back(40'h00_0000_0003);
    exp_q.push_back(evr(13, 32'hDEAD_BEEC));
    tick();
    ev_valid = '0;
    check("t6_clean_header", out_data, 40'h00_0000_0003);
    wait_idle("t6", 10);

`ifdef MICROARCHTRACE_STAGE_MASK_EN
    // Only wb enabled: dec-only cycles neither capture nor count as drops.
    stage_mask = 7'b000_0001;
    ev_valid   = 14'b00_1100_0000_0000;
    tick();
    ev_valid = '0;
    check("t7_masked_no_capture", {39'd0, busy}, '0);
    drive_capture(14'b00_0000_0000_0001, 1'b0, 6'd0);
    tick();
    ev_valid = 14'b00_0100_0000_0000;
    tick();
    tick();
    ev_valid = '0;
    wait_idle("t7a", 10);
    drive_capture(14'b00_0000_0000_0010, 1'b0, 6'd0);
    tick();
    ev_valid = '0;
    wait_idle("t7b", 10);
    stage_mask = '1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
